tmdsencode: RTL and testbench



---
 rtl/tmds_pkg.sv | 45 ++++
 rtl/tmds_qm.sv | 38 +++
 rtl/tmdsencode.sv | 98 +++++++++
 tb/tb_tmdsencode.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// TMDS encoder shared definitions: mode codes, fixed character
// tables (HDMI q_out order) and the wire-order bit reversal.
package tmds_pkg;

  localparam logic [1:0] TMDS_VIDEO = 2'd0;
  localparam logic [1:0] TMDS_CTL   = 2'd1;
  localparam logic [1:0] TMDS_TERC4 = 2'd2;
  localparam logic [1:0] TMDS_GUARD = 2'd3;

  // Element 0 is the rightmost entry of each concatenation.
  localparam logic [3:0][9:0] CTL_CODE = {
    10'h2AB, 10'h154, 10'h0AB, 10'h354
  };

  localparam logic [15:0][9:0] TERC4_CODE = {
    10'h2C3, 10'h163, 10'h271, 10'h28E,
    10'h2C6, 10'h19C, 10'h139, 10'h2CC,
    10'h13C, 10'h18E, 10'h11E, 10'h171,
    10'h2E2, 10'h2E4, 10'h263, 10'h29C
  };

  localparam logic [9:0] GUARD_C02 = 10'h2CC;
  localparam logic [9:0] GUARD_C1  = 10'h133;

  localparam logic [9:0] TMDS_RST_WORD = 10'h0AB;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] ctl;
    logic [3:0] aux;
    logic [8:0] qm;
    logic [3:0] n1;
  } s1_t;

  function automatic logic [9:0] bitrev10(
    input logic [9:0] w
  );
    logic [9:0] r;
    for (int k = 0; k < 10; k++) begin
      r[k] = w[9-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/tmds_qm.sv
// Transition-minimising first half of the TMDS video encoding,
// plus the ones count of the minimised byte.
module tmds_qm (
  input  logic [7:0] pix_i,
  output logic [8:0] qm_o,
  output logic [3:0] n1_o
);

  logic [3:0] n1d;
  logic       use_xnor;

  always_comb begin
    n1d = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n1d = n1d + {3'b000, pix_i[k]};
    end
    use_xnor = (n1d > 4'd4) ||
               (n1d == 4'd4 && !pix_i[0]);
  end

  always_comb begin
    qm_o    = 9'h000;
    qm_o[0] = pix_i[0];
    for (int k = 1; k < 8; k++) begin
      qm_o[k] = use_xnor ? ~(qm_o[k-1] ^ pix_i[k])
                         :  (qm_o[k-1] ^ pix_i[k]);
    end
    qm_o[8] = ~use_xnor;
  end

  always_comb begin
    n1_o = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n1_o = n1_o + {3'b000, qm_o[k]};
    end
  end

endmodule

// File: rtl/tmdsencode.sv
// Single-channel TMDS encoder: video with running disparity,
// control, TERC4 and guard-band characters; 2-cycle latency.
module tmdsencode
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_mode,
  input  logic [7:0] i_pix,
  input  logic [1:0] i_ctl,
  input  logic [3:0] i_aux,
  output logic [9:0] o_word
);

  logic [8:0] qm_w;
  logic [3:0] n1_w;

  s1_t s1_q, s1_d;

  logic signed [4:0] cnt_q, cnt_d;
  logic signed [4:0] n1s, n0s, diff;
  logic [9:0]        word_q, word_d;
  logic [9:0]        q_out;
  logic              qm8;

  tmds_qm u_qm (
    .pix_i (i_pix),
    .qm_o  (qm_w),
    .n1_o  (n1_w)
  );

  always_comb begin
    s1_d      = s1_q;
    s1_d.mode = i_mode;
    s1_d.ctl  = i_ctl;
    s1_d.aux  = i_aux;
    s1_d.qm   = qm_w;
    s1_d.n1   = n1_w;
  end

  always_comb begin
    qm8  = s1_q.qm[8];
    n1s  = $signed({1'b0, s1_q.n1});
    n0s  = 5'sd8 - n1s;
    diff = n1s - n0s;
  end

  always_comb begin
    q_out = 10'h000;
    cnt_d = 5'sd0;
    unique case (s1_q.mode)
      TMDS_VIDEO: begin
        if (cnt_q == 5'sd0 || diff == 5'sd0) begin
          q_out = {~qm8, qm8,
                   qm8 ? s1_q.qm[7:0] : ~s1_q.qm[7:0]};
          cnt_d = qm8 ? cnt_q + diff : cnt_q - diff;
        end else if ((cnt_q > 5'sd0 && diff > 5'sd0) ||
                     (cnt_q < 5'sd0 && diff < 5'sd0)) begin
          q_out = {1'b1, qm8, ~s1_q.qm[7:0]};
          cnt_d = cnt_q - diff +
                  (qm8 ? 5'sd2 : 5'sd0);
        end else begin
          q_out = {1'b0, qm8, s1_q.qm[7:0]};
          cnt_d = cnt_q + diff -
                  (qm8 ? 5'sd0 : 5'sd2);
        end
      end
      TMDS_CTL:   q_out = CTL_CODE[s1_q.ctl];
      TMDS_TERC4: q_out = TERC4_CODE[s1_q.aux];
      TMDS_GUARD: q_out = (CHANNEL == 1) ? GUARD_C1
                                         : GUARD_C02;
    endcase
    word_d = bitrev10(q_out);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_q <= '{mode: TMDS_CTL, ctl: 2'b00, aux: 4'h0,
                qm: 9'h000, n1: 4'h0};
      cnt_q  <= 5'sd0;
      word_q <= TMDS_RST_WORD;
    end else begin
      s1_q   <= s1_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign o_word = word_q;

  a_cnt_range : assert property (
    @(posedge i_clk) disable iff (!i_reset_n)
      (cnt_q >= -5'sd10) && (cnt_q <= 5'sd10)
  );

endmodule

// File: tb/tb_tmdsencode.sv
// Directed and randomised checks of the TMDS encoder using an
// independent decoder and a disparity tally on the output words.
module tb_tmdsencode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [7:0] pix;
  logic [1:0] ctl;
  logic [3:0] aux;
  logic [9:0] word0, word1;

  always #5 clk = ~clk;

  tmdsencode #(.CHANNEL(0)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_mode(mode),
    .i_pix(pix), .i_ctl(ctl), .i_aux(aux), .o_word(word0)
  );

  tmdsencode #(.CHANNEL(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_mode(mode),
    .i_pix(pix), .i_ctl(ctl), .i_aux(aux), .o_word(word1)
  );

  logic [9:0] ctl_tab [4] = '{
    10'h354, 10'h0AB, 10'h154, 10'h2AB
  };
  logic [9:0] terc_tab [16] = '{
    10'h29C, 10'h263, 10'h2E4, 10'h2E2,
    10'h171, 10'h11E, 10'h18E, 10'h13C,
    10'h2CC, 10'h139, 10'h19C, 10'h2C6,
    10'h28E, 10'h271, 10'h163, 10'h2C3
  };

  typedef struct {
    bit         video;
    bit         exact;
    bit         guard;
    logic [9:0] exp;
    logic [7:0] pix;
  } rec_t;

  rec_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   run_sum  = 0;

  task automatic check(input string tag,
                       input logic [9:0] got,
                       input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] rev(input logic [9:0] w);
    logic [9:0] r;
    for (int k = 0; k < 10; k++) r[k] = w[9-k];
    return r;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] w);
    logic [9:0] qo;
    logic [7:0] d, o;
    qo = rev(w);
    d  = qo[9] ? ~qo[7:0] : qo[7:0];
    o[0] = d[0];
    for (int k = 1; k < 8; k++)
      o[k] = qo[8] ? (d[k] ^ d[k-1]) : ~(d[k] ^ d[k-1]);
    return o;
  endfunction

  function automatic logic [9:0] exp_nv(input logic [1:0] m,
                                        input logic [1:0] c,
                                        input logic [3:0] a);
    logic [9:0] e;
    case (m)
      2'd1:    e = rev(ctl_tab[c]);
      2'd2:    e = rev(terc_tab[a]);
      default: e = 10'h0CD;
    endcase
    return e;
  endfunction

  task automatic verify(input rec_t r);
    int  ones;
    bit  in_rng;
    if (r.exact) check("word", word0, r.exp);
    if (r.guard) check("guard_ch1", word1, 10'h332);
    if (r.video) begin
      check("roundtrip", {2'b00, decode(word0)},
            {2'b00, r.pix});
      ones    = $countones(word0);
      run_sum = run_sum + 2 * ones - 10;
      in_rng  = (run_sum >= -10) && (run_sum <= 10);
      check("disp_range", {9'b0, in_rng}, 10'd1);
    end else begin
      run_sum = 0;
    end
  endtask

  task automatic cyc(input logic [1:0] m,
                     input logic [7:0] p,
                     input logic [1:0] c,
                     input logic [3:0] a,
                     input bit         ex,
                     input logic [9:0] e);
    rec_t r;
    @(negedge clk);
    if (q.size() >= 2) verify(q.pop_front());
    mode = m; pix = p; ctl = c; aux = a;
    r.video = (m == 2'd0);
    r.exact = ex;
    r.guard = (m == 2'd3);
    r.exp   = e;
    r.pix   = p;
    q.push_back(r);
  endtask

  task automatic flush();
    while (q.size() > 0) begin
      @(negedge clk);
      verify(q.pop_front());
    end
  endtask

  // Release between edges so the next driven input is the
  // first one stage 1 captures; two reset characters precede it.
  task automatic release_rst();
    rec_t r;
    @(posedge clk);
    #2 rst_n = 1'b1;
    q.delete();
    run_sum = 0;
    r.video = 1'b0; r.exact = 1'b1; r.guard = 1'b0;
    r.exp   = 10'h0AB; r.pix = 8'h00;
    q.push_back(r);
    q.push_back(r);
  endtask

  initial begin
    logic [1:0] m;
    logic [7:0] p;
    logic [1:0] c;
    logic [3:0] a;
    rst_n = 1'b0;
    mode = 2'd0; pix = 8'h5A; ctl = 2'd3; aux = 4'h7;
    repeat (2) @(posedge clk);
    #1 check("rst_word0", word0, 10'h0AB);
    check("rst_word1", word1, 10'h0AB);
    release_rst();

    repeat (3) cyc(2'd1, 8'h00, 2'd0, 4'h0, 1, 10'h0AB);
    cyc(2'd1, 8'h00, 2'd3, 4'h0, 1, 10'h355);
    cyc(2'd0, 8'h00, 2'd0, 4'h0, 1, 10'h002);
    cyc(2'd0, 8'h00, 2'd0, 4'h0, 1, 10'h3FF);
    cyc(2'd1, 8'h00, 2'd0, 4'h0, 1, 10'h0AB);
    cyc(2'd0, 8'hFF, 2'd0, 4'h0, 1, 10'h001);
    cyc(2'd0, 8'hFF, 2'd0, 4'h0, 1, 10'h3FC);
    for (int n = 0; n < 16; n++) begin
      a = 4'(n);
      if (n == 0)
        cyc(2'd2, 8'h00, 2'd0, a, 1, 10'h0E5);
      else if (n == 8)
        cyc(2'd2, 8'h00, 2'd0, a, 1, 10'h0CD);
      else
        cyc(2'd2, 8'h00, 2'd0, a, 1, rev(terc_tab[n]));
    end
    cyc(2'd3, 8'hA7, 2'd2, 4'h9, 1, 10'h0CD);
    cyc(2'd0, 8'h00, 2'd0, 4'h0, 1, 10'h002);

    for (int i = 0; i < 4000; i++) begin
      m = ($urandom_range(0, 9) < 7) ? 2'd0
          : 2'($urandom_range(1, 3));
      p = 8'($urandom);
      c = 2'($urandom);
      a = 4'($urandom);
      cyc(m, p, c, a, m != 2'd0, exp_nv(m, c, a));
    end

    cyc(2'd1, 8'h00, 2'd0, 4'h0, 1, 10'h0AB);
    cyc(2'd0, 8'h00, 2'd0, 4'h0, 1, 10'h002);
    flush();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_async", word0, 10'h0AB);
    release_rst();
    cyc(2'd0, 8'h00, 2'd0, 4'h0, 1, 10'h002);
    cyc(2'd0, 8'h00, 2'd0, 4'h0, 1, 10'h3FF);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
